// File: rtl/if_id_pipeline_ctrl.sv
// if_id_pipeline_ctrl
// Owns the program counter and the IF/ID pipeline register. Load-use stall
// requests from the hazard unit become a held PC/IF/ID plus one ID/EX bubble.
// Taken-branch flush requests become a PC redirect plus FLUSH_CYCLES cycles
// with an invalid IF/ID register.
//
// Optional feature macro: HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt.
//
// Ports:
//   clk            clock, all state updates on rising edge
//   rst            synchronous active-high reset
//   nop            hazard request, 2'b01 = load-use stall
//   flush          hazard request, 2'b01 = branch taken
//   branch_target  redirect address, sampled when a flush is accepted
//   imem_instr     instruction memory read data for the current pc
//   pc             fetch address (register)
//   ifid_instr     IF/ID instruction (register)
//   ifid_pc        IF/ID pc (register)
//   ifid_valid     IF/ID holds a real instruction (register)
//   stall_cnt      accepted stall count (HAZARD_STATS_EN only)
//   flush_cnt      accepted flush count (HAZARD_STATS_EN only)
//   idex_bubble    combinational, ID/EX loads a NOP on this edge
//   fetch_busy     combinational, high while in STALL or FLUSH
module if_id_pipeline_ctrl #(
  parameter int unsigned     PC_W         = 32,
  parameter int unsigned     INSTR_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int unsigned     PC_STEP      = 4,
  parameter int unsigned     FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         nop,
  input  logic [1:0]         flush,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic               idex_bubble,
`ifdef HAZARD_STATS_EN
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt,
`endif
  output logic               fetch_busy
);

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 3)) begin : gen_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..3");
  end

  localparam logic [1:0]      FlInit = 2'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0] Step   = PC_W'(PC_STEP);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  state_e             state_q, state_d;
  logic [1:0]         fl_cnt_q, fl_cnt_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               stall_acc, flush_acc;

  assign stall_acc = (nop == 2'b01) && (state_q == StRun);
  assign flush_acc = (flush == 2'b01) && (state_q != StFlush);

  always_comb begin
    state_d      = state_q;
    fl_cnt_d     = fl_cnt_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (flush_acc) begin
      // Flush wins over a same-cycle stall; Decode sees an invalid slot instead of a bubble.
      pc_d         = branch_target;
      ifid_instr_d = '0;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
      fl_cnt_d     = FlInit;
      state_d      = (FLUSH_CYCLES > 1) ? StFlush : StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (stall_acc) begin
            state_d = StStall;
          end else begin
            pc_d         = pc_q + Step;
            ifid_instr_d = imem_instr;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
          end
        end
        StStall: begin
          // nop is ignored here so a stuck request cannot starve fetch.
          pc_d         = pc_q + Step;
          ifid_instr_d = imem_instr;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          state_d      = StRun;
        end
        StFlush: begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          fl_cnt_d     = fl_cnt_q - 2'd1;
          if (fl_cnt_q == 2'd1) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      fl_cnt_q     <= '0;
      pc_q         <= RESET_PC;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fl_cnt_q     <= fl_cnt_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign pc          = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign idex_bubble = !rst && stall_acc && !flush_acc;
  assign fetch_busy  = !rst && (state_q != StRun);

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_acc) begin
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end else if (stall_acc) begin
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
